// File: rtl/mux_21.sv
// 2:1 selector with a combinational result, a one-cycle retimed copy and
// select-switch statistics (change pulse plus saturating switch counter).
module mux_21 #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             S,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             sel_q,
    output logic             sel_changed,
    output logic [CNT_W-1:0] switch_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic sel_diff;
    logic cnt_sat;

    // Plain ?: keeps agreeing bits intact when S is unknown.
    assign out      = S ? in2 : in1;
    assign sel_diff = (S != sel_q);
    assign cnt_sat  = (switch_count == CNT_MAX);

    // Retimed data and select copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            sel_q <= 1'b0;
        end else begin
            out_q <= out;
            sel_q <= S;
        end
    end

    // Switch monitor: pulse and counter move on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_changed  <= 1'b0;
            switch_count <= '0;
        end else begin
            sel_changed <= sel_diff;
            if (sel_diff && !cnt_sat) begin
                switch_count <= switch_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mux_21.sv
// Self-checking bench for mux_21: truth table, reset, select toggling,
// saturation, asynchronous reset and randomized traffic against a model.
module tb_mux_21;

    localparam int unsigned WA = 8;
    localparam int unsigned CA = 16;
    localparam int unsigned WB = 1;
    localparam int unsigned CB = 2;

    logic clk;
    logic clk_en;
    logic rst_n;

    logic [WA-1:0] a_in1, a_in2, a_out, a_out_q;
    logic          a_s, a_sel_q, a_chg;
    logic [CA-1:0] a_cnt;

    logic [WB-1:0] b_in1, b_in2, b_out, b_out_q;
    logic          b_s, b_sel_q, b_chg;
    logic [CB-1:0] b_cnt;

    int checks = 0;
    int errors = 0;

    // reference state for instance A
    logic [WA-1:0] m_out_q;
    logic          m_sel;
    logic          m_chg;
    int            m_cnt;

    typedef struct {
        logic s;
        logic i1;
        logic i2;
        logic exp;
    } tt_t;

    tt_t tt[8];
    int  sat_exp[6];
    logic tog_s[5];
    logic tog_chg[5];

    mux_21 #(.WIDTH(WA), .CNT_W(CA)) u_a (
        .clk(clk), .rst_n(rst_n), .in1(a_in1), .in2(a_in2), .S(a_s),
        .out(a_out), .out_q(a_out_q), .sel_q(a_sel_q),
        .sel_changed(a_chg), .switch_count(a_cnt)
    );

    mux_21 #(.WIDTH(WB), .CNT_W(CB)) u_b (
        .clk(clk), .rst_n(rst_n), .in1(b_in1), .in2(b_in2), .S(b_s),
        .out(b_out), .out_q(b_out_q), .sel_q(b_sel_q),
        .sel_changed(b_chg), .switch_count(b_cnt)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_out_q = '0;
        m_sel   = 1'b0;
        m_chg   = 1'b0;
        m_cnt   = 0;
    endtask

    // Drive A for one cycle (called just after a falling edge) and check it.
    task automatic a_step(input logic s, input logic [WA-1:0] x, input logic [WA-1:0] y);
        logic [WA-1:0] sel_val;
        a_s   = s;
        a_in1 = x;
        a_in2 = y;
        sel_val = (s == 1'b1) ? y : x;
        #1;
        chk("a_out", 32'(a_out), 32'(sel_val));
        @(posedge clk);
        m_chg   = (s != m_sel);
        if (m_chg && m_cnt < (1 << CA) - 1) m_cnt = m_cnt + 1;
        m_sel   = s;
        m_out_q = sel_val;
        @(negedge clk);
        chk("a_out_q", 32'(a_out_q), 32'(m_out_q));
        chk("a_sel_q", 32'(a_sel_q), 32'(m_sel));
        chk("a_sel_changed", 32'(a_chg), 32'(m_chg));
        chk("a_switch_count", 32'(a_cnt), 32'(m_cnt));
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        clk_en = 1'b0;
        rst_n  = 1'b1;
        a_s = 1'b0; a_in1 = '0; a_in2 = '0;
        b_s = 1'b0; b_in1 = '0; b_in2 = '0;
        model_reset();

        tt[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tt[1] = '{1'b0, 1'b0, 1'b1, 1'b0};
        tt[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
        tt[3] = '{1'b0, 1'b1, 1'b1, 1'b1};
        tt[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        tt[5] = '{1'b1, 1'b0, 1'b1, 1'b1};
        tt[6] = '{1'b1, 1'b1, 1'b0, 1'b0};
        tt[7] = '{1'b1, 1'b1, 1'b1, 1'b1};
        sat_exp = '{1, 2, 3, 3, 3, 3};
        tog_s   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tog_chg = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        // exhaustive truth table with the clock stopped
        for (int i = 0; i < 8; i++) begin
            b_s = tt[i].s; b_in1 = tt[i].i1; b_in2 = tt[i].i2;
            #1;
            chk($sformatf("truth_%0d", i), 32'(b_out), 32'(tt[i].exp));
            #99;
        end
        #900;
        chk("truth_hold", 32'(b_out), 32'(tt[7].exp));

        // reset asserted, combinational path still live
        rst_n = 1'b0;
        a_s = 1'b1; a_in1 = 8'h00; a_in2 = 8'hA5;
        #1;
        chk("rst_out", 32'(a_out), 32'h0000_00A5);
        chk("rst_out_q", 32'(a_out_q), 32'h0);
        chk("rst_sel_q", 32'(a_sel_q), 32'h0);
        chk("rst_sel_changed", 32'(a_chg), 32'h0);
        chk("rst_switch_count", 32'(a_cnt), 32'h0);
        chk("rst_b_switch_count", 32'(b_cnt), 32'h0);

        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_hold_out_q", 32'(a_out_q), 32'h0);
        chk("rst_hold_sel_q", 32'(a_sel_q), 32'h0);
        rst_n = 1'b1;
        model_reset();

        // registered path: S=0, in1=1
        a_step(1'b0, 8'h01, 8'h00);
        chk("reg_out_q", 32'(a_out_q), 32'h1);
        chk("reg_sel_changed", 32'(a_chg), 32'h0);

        // select toggling 0,1,1,0,1 (first step above was S=0)
        for (int i = 1; i < 5; i++) begin
            a_step(tog_s[i], 8'($urandom), 8'($urandom));
            chk($sformatf("toggle_chg_%0d", i), 32'(a_chg), 32'(tog_chg[i]));
        end
        chk("toggle_count", 32'(a_cnt), 32'd3);

        // async reset mid-run with switch_count=2; S high at release counts
        reset_pulse();
        a_step(1'b1, 8'h3C, 8'hC3);
        chk("release_high_s_count", 32'(a_cnt), 32'd1);
        a_step(1'b0, 8'h3C, 8'hC3);
        chk("pre_async_count", 32'(a_cnt), 32'd2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_q", 32'(a_out_q), 32'h0);
        chk("async_sel_q", 32'(a_sel_q), 32'h0);
        chk("async_sel_changed", 32'(a_chg), 32'h0);
        chk("async_switch_count", 32'(a_cnt), 32'h0);
        chk("async_out", 32'(a_out), 32'h0000_003C);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // saturation on the 2-bit counter instance
        reset_pulse();
        for (int k = 0; k < 6; k++) begin
            b_s = (k % 2 == 0) ? 1'b1 : 1'b0;
            @(negedge clk);
            chk($sformatf("sat_chg_%0d", k), 32'(b_chg), 32'h1);
            chk($sformatf("sat_cnt_%0d", k), 32'(b_cnt), 32'(sat_exp[k]));
        end
        b_s = 1'b0;
        @(negedge clk);
        chk("sat_hold_cnt", 32'(b_cnt), 32'd3);
        chk("sat_hold_chg", 32'(b_chg), 32'h0);

        // randomized traffic against the reference model
        reset_pulse();
        for (int n = 0; n < 300; n++) begin
            a_step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
